// File: rtl/spi_master_ctrl.sv
// Transaction-level SPI master for the single-slave SPI RAM: expands one parallel
// write/read request into two 10-bit command frames and returns captured read data.
module spi_master_ctrl #(
    parameter int GAP      = 2,
    parameter int MISO_DLY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int GAP_W  = $clog2(GAP + 1);
    localparam int WAIT_W = (MISO_DLY < 2) ? 1 : $clog2(MISO_DLY);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MISO_DLY < 1) ? 0 : MISO_DLY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SEL     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_GAP     = 3'd6
    } state_t;

    // Command encoding is {rw, phase}: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
    function automatic logic [9:0] frame_word(input logic phase_b, input logic rw,
                                              input logic [7:0] addr, input logic [7:0] wdata);
        logic [7:0] payload;
        payload = phase_b ? (rw ? 8'h00 : wdata) : addr;
        return {rw, phase_b, payload};
    endfunction

    state_t              r_state;
    logic                r_phase_b;
    logic                r_rw;
    logic [7:0]          r_addr;
    logic [7:0]          r_wdata;
    logic [3:0]          r_shift_cnt;
    logic [2:0]          r_cap_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [6:0]          r_rx_sr;
    logic                r_ss_n;
    logic                r_mosi;
    logic                r_rsp_valid;
    logic [7:0]          r_rsp_rdata;

    logic [9:0]          w_frame_word;
    logic                w_rd_frame;

    assign w_frame_word = frame_word(r_phase_b, r_rw, r_addr, r_wdata);
    assign w_rd_frame   = r_phase_b & r_rw;

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = ~req_ready;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    // Frame sequencer; SS_n/MOSI are loaded with the value for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase_b   <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_shift_cnt <= 4'd0;
            r_cap_cnt   <= 3'd0;
            r_gap_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_rx_sr     <= 7'h00;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mosi <= 1'b0;
                    if (req_valid) begin
                        r_rw      <= req_rw;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_phase_b <= 1'b0;
                        r_ss_n    <= 1'b0;
                        r_state   <= ST_START;
                    end else begin
                        r_ss_n    <= 1'b1;
                    end
                end
                ST_START: begin
                    r_mosi  <= w_frame_word[9];
                    r_state <= ST_SEL;
                end
                ST_SEL: begin
                    r_mosi      <= w_frame_word[9];
                    r_shift_cnt <= 4'd0;
                    r_state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_shift_cnt == 4'd9) begin
                        r_mosi <= 1'b0;
                        if (w_rd_frame) begin
                            r_wait_cnt <= '0;
                            r_cap_cnt  <= 3'd0;
                            r_state    <= (MISO_DLY == 0) ? ST_CAPTURE : ST_WAIT;
                        end else begin
                            r_ss_n     <= 1'b1;
                            r_gap_cnt  <= '0;
                            r_state    <= ST_GAP;
                        end
                    end else begin
                        r_mosi      <= w_frame_word[4'd8 - r_shift_cnt];
                        r_shift_cnt <= r_shift_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_rx_sr <= {r_rx_sr[5:0], MISO};
                    if (r_cap_cnt == 3'd7) begin
                        r_rsp_rdata <= {r_rx_sr, MISO};
                        r_rsp_valid <= 1'b1;
                        r_ss_n      <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cap_cnt   <= r_cap_cnt + 3'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (!r_phase_b) begin
                            r_phase_b <= 1'b1;
                            r_ss_n    <= 1'b0;
                            r_state   <= ST_START;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
